// File: rtl/writeback_arbiter_pkg.sv
// Shared writeback types and default sizing for the unit-to-register-file path.
// Pure declarations: no latency, no flow control.
package writeback_arbiter_pkg;

  localparam int NUM_WB_UNITS = 4;
  localparam int LOG2_MAX_IDS = 3;
  localparam int XLEN         = 32;

  typedef struct packed {
    logic [LOG2_MAX_IDS-1:0] id;
    logic [XLEN-1:0]         data;
  } wb_packet_t;

  typedef logic [NUM_WB_UNITS-1:0][LOG2_MAX_IDS-1:0] unit_id_array_t;
  typedef logic [NUM_WB_UNITS-1:0][XLEN-1:0]         unit_rd_array_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Writeback bundle: per-unit done/id/rd with returned ack, plus the registered output handshake.
// master = units and register-file side, slave = the arbiter.
interface writeback_arbiter_if
  import writeback_arbiter_pkg::*;
#(
  parameter int NUM_UNITS  = NUM_WB_UNITS,
  parameter int DATA_WIDTH = XLEN,
  parameter int ID_WIDTH   = LOG2_MAX_IDS
);
  localparam int UNIT_W = $clog2(NUM_UNITS);

  logic [NUM_UNITS-1:0]                 unit_done;
  logic [NUM_UNITS-1:0][ID_WIDTH-1:0]   unit_id;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] unit_rd;
  logic [NUM_UNITS-1:0]                 unit_ack;

  logic                  wb_valid;
  logic                  wb_ready;
  logic [ID_WIDTH-1:0]   wb_id;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [UNIT_W-1:0]     wb_unit;

  modport master (
    output unit_done, unit_id, unit_rd, wb_ready,
    input  unit_ack, wb_valid, wb_id, wb_data, wb_unit
  );

  modport slave (
    input  unit_done, unit_id, unit_rd, wb_ready,
    output unit_ack, wb_valid, wb_id, wb_data, wb_unit
  );

endinterface

// File: rtl/writeback_arbiter_rr.sv
// Combinational round-robin pick: searches last_grant+1 onward, wrapping, returns one-hot and index.
// Zero latency; no state, the caller owns last_grant.
module round_robin_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int IDX_W     = $clog2(NUM_UNITS)
) (
  input  logic [NUM_UNITS-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [NUM_UNITS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 any_request
);

  logic             found;
  logic [IDX_W-1:0] cand_idx;
  int               cand;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    // k runs 1..N so the previous winner is considered last
    for (int k = 1; k <= NUM_UNITS; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_UNITS) cand = cand - NUM_UNITS;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found     = 1'b1;
        grant_idx = cand_idx;
      end
    end
    grant            = '0;
    grant[grant_idx] = found;
  end

  assign any_request = |req;

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin writeback arbiter: ack is combinational in the done cycle, result registered for N+1.
// Output stalls (no acks) while wb_valid & ~wb_ready; drain and refill in the same cycle without a bubble.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int NUM_UNITS  = NUM_WB_UNITS,
  parameter int DATA_WIDTH = XLEN,
  parameter int ID_WIDTH   = LOG2_MAX_IDS
) (
  input logic              clk,
  input logic              rst_n,
  writeback_arbiter_if.slave bus
);

  localparam int UNIT_W = $clog2(NUM_UNITS);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
  } pkt_t;

  logic [NUM_UNITS-1:0] rr_grant;
  logic [UNIT_W-1:0]    grant_idx;
  logic                 any_request;
  logic [UNIT_W-1:0]    last_grant;
  logic                 can_accept;
  logic                 grant_vld;

  pkt_t              wb_q;
  logic              wb_valid_q;
  logic [UNIT_W-1:0] wb_unit_q;

  round_robin_arbiter #(
    .NUM_UNITS (NUM_UNITS),
    .IDX_W     (UNIT_W)
  ) u_rr (
    .req         (bus.unit_done),
    .last_grant  (last_grant),
    .grant       (rr_grant),
    .grant_idx   (grant_idx),
    .any_request (any_request)
  );

  assign can_accept = ~wb_valid_q | bus.wb_ready;
  // rst_n gate keeps a unit from dropping its result while the output stage is held in reset
  assign grant_vld  = can_accept & any_request & rst_n;

  assign bus.unit_ack = grant_vld ? rr_grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= UNIT_W'(NUM_UNITS - 1);
      wb_valid_q <= 1'b0;
      wb_unit_q  <= '0;
      wb_q       <= '0;
    end else if (grant_vld) begin
      last_grant <= grant_idx;
      wb_valid_q <= 1'b1;
      wb_unit_q  <= grant_idx;
      wb_q.id    <= bus.unit_id[grant_idx];
      wb_q.data  <= bus.unit_rd[grant_idx];
    end else if (bus.wb_ready) begin
      wb_valid_q <= 1'b0;
    end
  end

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_id    = wb_q.id;
  assign bus.wb_data  = wb_q.data;
  assign bus.wb_unit  = wb_unit_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed table bench for writeback_arbiter: per-vector ack and next-cycle output checks,
// plus reset-at-start and asynchronous mid-stream reset sequences.
module tb_writeback_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 3;

  logic clk;
  logic rst_n;

  writeback_arbiter_if #(.NUM_UNITS(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  writeback_arbiter #(.NUM_UNITS(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] done;
    logic         ready;
    logic [N-1:0] exp_ack;
    logic         exp_vld;
    int           exp_unit;
    bit           fair;
  } vec_t;

  vec_t          tbl [20];
  logic [IW-1:0] uid [N];
  logic [DW-1:0] udat [N];
  int            fair_cnt [N];
  int            n_vec;
  int            n_bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_wb(input string tag, input logic vld, input int unit);
    chk({tag, ".wb_valid"}, 64'(bus.wb_valid), 64'(vld));
    chk({tag, ".wb_unit"},  64'(bus.wb_unit),  64'(unit));
    chk({tag, ".wb_id"},    64'(bus.wb_id),    64'(uid[unit]));
    chk({tag, ".wb_data"},  64'(bus.wb_data),  64'(udat[unit]));
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    uid   = '{3'd1, 3'd3, 3'd5, 3'd7};
    udat  = '{32'h1111_0000, 32'h2222_0001, 32'hDEAD_BEEF, 32'h4444_0003};
    for (int u = 0; u < N; u++) fair_cnt[u] = 0;

    // done, ready, exp_ack, exp_vld(next), exp_unit(next), fairness window
    tbl[0]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 0, 1'b0}; // first grant after reset
    tbl[1]  = '{4'h4, 1'b1, 4'b0100, 1'b1, 2, 1'b0}; // single requester unit 2
    tbl[2]  = '{4'h0, 1'b1, 4'b0000, 1'b0, 2, 1'b0}; // drain, data held
    tbl[3]  = '{4'h8, 1'b1, 4'b1000, 1'b1, 3, 1'b0}; // park last_grant at 3
    tbl[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 0, 1'b1};
    tbl[5]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 1, 1'b1};
    tbl[6]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2, 1'b1};
    tbl[7]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 3, 1'b1};
    tbl[8]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 0, 1'b1};
    tbl[9]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 1, 1'b1};
    tbl[10] = '{4'hF, 1'b1, 4'b0100, 1'b1, 2, 1'b1};
    tbl[11] = '{4'hF, 1'b1, 4'b1000, 1'b1, 3, 1'b1};
    tbl[12] = '{4'hA, 1'b0, 4'b0000, 1'b1, 3, 1'b0}; // stall x3
    tbl[13] = '{4'hA, 1'b0, 4'b0000, 1'b1, 3, 1'b0};
    tbl[14] = '{4'hA, 1'b0, 4'b0000, 1'b1, 3, 1'b0};
    tbl[15] = '{4'hA, 1'b1, 4'b0010, 1'b1, 1, 1'b0}; // drain+replace, no bubble
    tbl[16] = '{4'hA, 1'b1, 4'b1000, 1'b1, 3, 1'b0};
    tbl[17] = '{4'h0, 1'b1, 4'b0000, 1'b0, 3, 1'b0}; // drain without request
    tbl[18] = '{4'h1, 1'b0, 4'b0001, 1'b1, 0, 1'b0}; // empty stage accepts despite ready=0
    tbl[19] = '{4'h1, 1'b0, 4'b0000, 1'b1, 0, 1'b0}; // full and stalled

    for (int u = 0; u < N; u++) begin
      bus.unit_id[u] = uid[u];
      bus.unit_rd[u] = udat[u];
    end
    bus.unit_done = 4'hF;
    bus.wb_ready  = 1'b1;
    rst_n         = 1'b0;

    // Reset held with every unit requesting
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset.unit_ack", 64'(bus.unit_ack), 64'h0);
    chk("reset.wb_valid", 64'(bus.wb_valid), 64'h0);
    chk("reset.wb_data",  64'(bus.wb_data),  64'h0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rst_n         = 1'b1;
      bus.unit_done = tbl[i].done;
      bus.wb_ready  = tbl[i].ready;
      #1;
      chk($sformatf("v%0d.unit_ack", i), 64'(bus.unit_ack), 64'(tbl[i].exp_ack));
      if (tbl[i].fair)
        for (int u = 0; u < N; u++) if (bus.unit_ack[u]) fair_cnt[u]++;
      @(posedge clk);
      #1;
      chk_wb($sformatf("v%0d", i), tbl[i].exp_vld, tbl[i].exp_unit);
    end

    for (int u = 0; u < N; u++)
      chk($sformatf("fair.count_u%0d", u), 64'(fair_cnt[u]), 64'd2);

    // Asynchronous reset between edges while the output stage is full
    bus.unit_done = 4'hF;
    bus.wb_ready  = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset.wb_valid", 64'(bus.wb_valid), 64'h0);
    chk("areset.wb_data",  64'(bus.wb_data),  64'h0);
    chk("areset.unit_ack", 64'(bus.unit_ack), 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("areset.restart_ack", 64'(bus.unit_ack), 64'b0001);
    @(posedge clk);
    #1;
    chk_wb("areset.restart", 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
